// File: rtl/ethernet_crc_stream.sv
// rtl/ethernet_crc_stream.sv - streaming Ethernet CRC-32 tap with FCS generation/check and frame counters
module ethernet_crc_stream #(
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_valid,
    input  logic                    s_ready,
    input  logic                    s_last,
    input  logic                    abort,
    input  logic                    cnt_clear,
    output logic [31:0]             crc_reg,
    output logic [31:0]             fcs,
    output logic                    fcs_ok,
    output logic [15:0]             frame_len,
    output logic                    result_valid,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    in_frame
);

    localparam logic [31:0]      POLY    = 32'hEDB88320;
    localparam logic [31:0]      SEED    = 32'hFFFFFFFF;
    localparam logic [31:0]      RESIDUE = 32'hDEBB20E3;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t      state;
    logic [15:0] len_acc;

    logic        accept;
    logic        complete;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic        ok_next;
    logic [4:0]  beat_bytes;
    logic [15:0] len_base;
    logic [16:0] len_sum;
    logic [15:0] len_next;

    // One reflected byte-step: LSB-first shift through the polynomial.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign accept   = s_valid & s_ready;
    assign complete = accept & s_last & ~abort;
    assign in_frame = (state == FRAME);

    // Byte-lane cascade: kept lanes fold into the CRC in ascending order, holes are skipped.
    always_comb begin
        crc_base   = (state == IDLE) ? SEED : crc_reg;
        len_base   = (state == IDLE) ? 16'h0000 : len_acc;
        crc_next   = crc_base;
        beat_bytes = 5'd0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (s_keep[i]) begin
                crc_next   = crc_byte(crc_next, s_data[8*i +: 8]);
                beat_bytes = beat_bytes + 5'd1;
            end
        end
        len_sum  = {1'b0, len_base} + {12'h000, beat_bytes};
        len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        ok_next  = (crc_next == RESIDUE);
    end

    // Frame FSM, running CRC/length, registered per-frame results and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            crc_reg      <= SEED;
            len_acc      <= 16'h0000;
            fcs          <= 32'h00000000;
            fcs_ok       <= 1'b0;
            frame_len    <= 16'h0000;
            result_valid <= 1'b0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            result_valid <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                crc_reg <= SEED;
                len_acc <= 16'h0000;
            end else if (accept) begin
                crc_reg <= crc_next;
                len_acc <= len_next;
                if (s_last) begin
                    state        <= IDLE;
                    result_valid <= 1'b1;
                    fcs          <= ~crc_next;
                    fcs_ok       <= ok_next;
                    frame_len    <= len_next;
                end else begin
                    state <= FRAME;
                end
            end

            if (cnt_clear) begin
                frame_cnt <= '0;
                err_cnt   <= '0;
            end else if (complete) begin
                if (frame_cnt != '1) begin
                    frame_cnt <= frame_cnt + CNT_ONE;
                end
                if (!ok_next && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ethernet_crc_stream.sv
// tb/tb_ethernet_crc_stream.sv - self-checking bench for ethernet_crc_stream
module tb_ethernet_crc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid, s_ready, s_last, abort, cnt_clear;
    logic [31:0] crc_reg, fcs;
    logic        fcs_ok, result_valid, in_frame;
    logic [15:0] frame_len;
    logic [1:0]  frame_cnt, err_cnt;

    logic [7:0]  b1_data;
    logic [0:0]  b1_keep;
    logic        b1_valid, b1_ready, b1_last, b1_abort, b1_clear;
    logic [31:0] b1_crc_reg, b1_fcs;
    logic        b1_fcs_ok, b1_result_valid, b1_in_frame;
    logic [15:0] b1_frame_len;
    logic [31:0] b1_frame_cnt, b1_err_cnt;

    ethernet_crc_stream #(.DATA_BYTES(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last), .abort(abort), .cnt_clear(cnt_clear),
        .crc_reg(crc_reg), .fcs(fcs), .fcs_ok(fcs_ok), .frame_len(frame_len),
        .result_valid(result_valid), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .in_frame(in_frame)
    );

    ethernet_crc_stream #(.DATA_BYTES(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .s_data(b1_data), .s_keep(b1_keep), .s_valid(b1_valid),
        .s_ready(b1_ready), .s_last(b1_last), .abort(b1_abort), .cnt_clear(b1_clear),
        .crc_reg(b1_crc_reg), .fcs(b1_fcs), .fcs_ok(b1_fcs_ok), .frame_len(b1_frame_len),
        .result_valid(b1_result_valid), .frame_cnt(b1_frame_cnt), .err_cnt(b1_err_cnt),
        .in_frame(b1_in_frame)
    );

    typedef struct {
        logic [31:0] fcs;
        logic        ok;
        logic [15:0] len;
    } exp_t;

    typedef struct {
        logic [63:0] d0;
        logic [7:0]  k0;
        logic [63:0] d1;
        logic [7:0]  k1;
        bit          two;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_results = 0;

    localparam logic [63:0] D_1TO8   = 64'h3837363534333231;
    localparam logic [63:0] D_9      = 64'h0000000000000039;
    localparam logic [63:0] D_9FCS   = 64'h000000CBF4392639;
    localparam logic [63:0] D_1TO8X  = 64'h3837363534333230;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference: bit-serial reflected CRC over the kept lanes of up to two beats.
    function automatic exp_t model(input logic [63:0] d0, input logic [7:0] k0,
                                   input logic [63:0] d1, input logic [7:0] k1, input bit two);
        logic [31:0] c;
        logic [63:0] d;
        logic [7:0]  k;
        logic        fb;
        int          n;
        exp_t        r;
        c = 32'hFFFFFFFF;
        n = 0;
        for (int b = 0; b < 2; b++) begin
            d = (b == 0) ? d0 : d1;
            k = (b == 0) ? k0 : k1;
            if (b == 0 || two) begin
                for (int l = 0; l < 8; l++) begin
                    if (k[l]) begin
                        n++;
                        for (int j = 0; j < 8; j++) begin
                            fb = c[0] ^ d[8*l + j];
                            c  = {1'b0, c[31:1]};
                            if (fb) c = c ^ 32'hEDB88320;
                        end
                    end
                end
            end
        end
        r.fcs = ~c;
        r.ok  = (c == 32'hDEBB20E3);
        r.len = 16'(n);
        return r;
    endfunction

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input bit last,
                        input bit stall, input bit push, input exp_t e);
        s_data  = d;
        s_keep  = k;
        s_last  = last;
        s_valid = 1'b1;
        if (stall) begin
            s_ready = 1'b0;
            @(posedge clk); #1;
        end
        s_ready = 1'b1;
        if (last && push) sb.push_back(e);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send(input vec_t v, input bit stall);
        if (v.two) begin
            beat(v.d0, v.k0, 1'b0, stall, 1'b0, v.e);
            beat(v.d1, v.k1, 1'b1, stall, 1'b1, v.e);
        end else begin
            beat(v.d0, v.k0, 1'b1, stall, 1'b1, v.e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            n_results++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got result_valid=1 expected no result");
            end else begin
                mon_e = sb.pop_front();
                check("fcs", fcs, mon_e.fcs);
                check("fcs_ok", 32'(fcs_ok), 32'(mon_e.ok));
                check("frame_len", 32'(frame_len), 32'(mon_e.len));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t rx_good, rx_bad, plain;
        int   r0;

        reset = 1'b1;
        s_data = '0; s_keep = '0; s_valid = 0; s_ready = 1; s_last = 0; abort = 0; cnt_clear = 0;
        b1_data = '0; b1_keep = 1'b1; b1_valid = 0; b1_ready = 1; b1_last = 0; b1_abort = 0; b1_clear = 0;

        vecs[0] = '{D_1TO8, 8'hFF, D_9, 8'h01, 1'b1, '{32'hCBF43926, 1'b0, 16'd9}};
        vecs[1] = '{D_1TO8, 8'hFF, D_9FCS, 8'h1F, 1'b1, '{32'h2144DF1C, 1'b1, 16'd13}};
        vecs[2] = '{D_1TO8X, 8'hFF, D_9FCS, 8'h1F, 1'b1, model(D_1TO8X, 8'hFF, D_9FCS, 8'h1F, 1'b1)};
        vecs[3] = '{64'h36353433AA32AA31, 8'hF5, 64'h000000003938AA37, 8'h0D, 1'b1,
                    '{32'hCBF43926, 1'b0, 16'd9}};
        vecs[4] = '{D_1TO8, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, model(D_1TO8, 8'hFF, 64'h0, 8'h00, 1'b1)};
        vecs[5] = '{64'h1122334455667788, 8'h00, 64'h0, 8'h00, 1'b0, '{32'h00000000, 1'b0, 16'd0}};
        rx_good = vecs[1];
        rx_bad  = vecs[2];
        plain   = vecs[0];

        idle(2);
        check("rst_crc_reg", crc_reg, 32'hFFFFFFFF);
        check("rst_fcs", fcs, 32'h0);
        check("rst_fcs_ok", 32'(fcs_ok), 32'h0);
        check("rst_frame_len", 32'(frame_len), 32'h0);
        check("rst_result_valid", 32'(result_valid), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_in_frame", 32'(in_frame), 32'h0);
        reset = 1'b0;
        idle(1);

        // One byte per beat on the single-lane instance.
        for (int i = 0; i < 9; i++) begin
            b1_data  = 8'h31 + 8'(i);
            b1_valid = 1'b1;
            b1_last  = (i == 8);
            @(posedge clk); #1;
            if (i == 7) check("b1_no_early_result", 32'(b1_result_valid), 32'h0);
        end
        b1_valid = 1'b0;
        b1_last  = 1'b0;
        check("b1_result_valid", 32'(b1_result_valid), 32'h1);
        check("b1_fcs", b1_fcs, 32'hCBF43926);
        check("b1_frame_len", 32'(b1_frame_len), 32'd9);
        check("b1_frame_cnt", b1_frame_cnt, 32'd1);
        idle(1);
        check("b1_result_pulse", 32'(b1_result_valid), 32'h0);

        // Table of frames: full beats, residue check, bit error, sparse keep, empty last beat, empty frame.
        for (int i = 0; i < 6; i++) begin
            send(vecs[i], (i % 2) == 1);
            if (i == 0) check("latency_result_valid", 32'(result_valid), 32'h1);
        end
        idle(2);
        check("tbl_frame_cnt_sat", 32'(frame_cnt), 32'd3);
        check("tbl_err_cnt_sat", 32'(err_cnt), 32'd3);

        cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
        check("clr_frame_cnt", 32'(frame_cnt), 32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);

        send(rx_good, 1'b0);
        check("rx_good_frame_cnt", 32'(frame_cnt), 32'd1);
        check("rx_good_err_cnt", 32'(err_cnt), 32'd0);
        send(rx_bad, 1'b0);
        check("rx_bad_frame_cnt", 32'(frame_cnt), 32'd2);
        check("rx_bad_err_cnt", 32'(err_cnt), 32'd1);
        idle(2);

        // Back-to-back frames with s_ready toggling.
        r0 = n_results;
        send(plain, 1'b1);
        send(rx_good, 1'b1);
        idle(3);
        check("b2b_result_pulses", 32'(n_results - r0), 32'd2);

        // Abort coincident with an accepted last beat.
        cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
        send(plain, 1'b0);
        idle(1);
        beat(D_1TO8, 8'hFF, 1'b0, 1'b0, 1'b0, plain.e);
        abort = 1'b1;
        beat(D_9, 8'h01, 1'b1, 1'b0, 1'b0, plain.e);
        abort = 1'b0;
        check("abort_result_valid", 32'(result_valid), 32'h0);
        check("abort_crc_reg", crc_reg, 32'hFFFFFFFF);
        check("abort_in_frame", 32'(in_frame), 32'h0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd1);
        check("abort_err_cnt", 32'(err_cnt), 32'd1);
        send(plain, 1'b0);
        idle(2);
        check("post_abort_frame_cnt", 32'(frame_cnt), 32'd2);

        // Five bad frames saturate a 2-bit error counter.
        cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) send(rx_bad, 1'b0);
        idle(2);
        check("sat_err_cnt", 32'(err_cnt), 32'd3);
        check("sat_frame_cnt", 32'(frame_cnt), 32'd3);

        // Clear coincident with a completing frame.
        beat(D_1TO8, 8'hFF, 1'b0, 1'b0, 1'b0, plain.e);
        cnt_clear = 1'b1;
        beat(D_9, 8'h01, 1'b1, 1'b0, 1'b1, plain.e);
        cnt_clear = 1'b0;
        check("clr_win_frame_cnt", 32'(frame_cnt), 32'd0);
        check("clr_win_err_cnt", 32'(err_cnt), 32'd0);
        idle(2);

        // Reset in the middle of a frame.
        send(rx_bad, 1'b0);
        beat(D_1TO8, 8'hFF, 1'b0, 1'b0, 1'b0, plain.e);
        check("mid_in_frame", 32'(in_frame), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_crc_reg", crc_reg, 32'hFFFFFFFF);
        check("mid_rst_fcs", fcs, 32'h0);
        check("mid_rst_fcs_ok", 32'(fcs_ok), 32'h0);
        check("mid_rst_frame_len", 32'(frame_len), 32'h0);
        check("mid_rst_result_valid", 32'(result_valid), 32'h0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        check("mid_rst_in_frame", 32'(in_frame), 32'h0);
        idle(2);
        reset = 1'b0;
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
